// File: rtl/imem_line_fetch.sv
// -----------------------------------------------------------------------------
// imem_line_fetch
//
// Line-refill engine between the instruction cache miss port and a 16-bit
// external instruction memory. A held miss request starts a line refill:
// eight consecutive halfwords are read from the line-aligned base address.
// Each pair is packed big-endian (even halfword in the upper half) into one
// 32-bit word. The four words are returned as a burst of one-cycle beats, and
// the fourth beat is flagged as last.
//
// Parameters
//   DATA_WIDTH     burst word width, must equal 2*MEM_WIDTH
//   MEM_WIDTH      external memory data width
//   ADDRESS_WIDTH  halfword address width (line = 8 halfwords)
//
// Ports
//   i_Clk          clock
//   i_Reset_n      asynchronous active-low reset
//   i_Req_Valid    miss request, level, held for the whole line
//   i_Req_Address  halfword line address, bits [2:0] ignored
//   o_Valid        beat valid, one-cycle pulse per word
//   o_Last         high with the fourth beat only
//   o_Data         burst word, holds its value between beats
//   o_Mem_Read     external read request, held until acknowledged
//   o_Mem_Address  halfword address of the current read
//   i_Mem_Ack      read complete, i_Mem_Data valid in this cycle
//   i_Mem_Data     read data
//
// Behaviour summary
//   IDLE    : waits for a request and latches the line base.
//   READ    : walks the eight halfwords and emits a beat on every odd ack.
//   DRAIN   : the request was withdrawn mid-line. The access in flight is
//             allowed to finish so the memory handshake is never broken.
//             No beats are produced.
//   RELEASE : the line is complete. This state waits for the request level
//             to drop, so the request still held during the final beat
//             cannot start a second refill.
// -----------------------------------------------------------------------------
module imem_line_fetch #(
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_WIDTH     = 16,
    parameter int ADDRESS_WIDTH = 22
) (
    input  logic                     i_Clk,
    input  logic                     i_Reset_n,
    input  logic                     i_Req_Valid,
    input  logic [ADDRESS_WIDTH-1:0] i_Req_Address,
    output logic                     o_Valid,
    output logic                     o_Last,
    output logic [DATA_WIDTH-1:0]    o_Data,
    output logic                     o_Mem_Read,
    output logic [ADDRESS_WIDTH-1:0] o_Mem_Address,
    input  logic                     i_Mem_Ack,
    input  logic [MEM_WIDTH-1:0]     i_Mem_Data
);

    // Clears the halfword-within-line bits of a request address.
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK = ~ADDRESS_WIDTH'(7);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_READ    = 2'd1,
        S_DRAIN   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t r_State;
    state_t w_Next_State;

    // Line context
    logic [ADDRESS_WIDTH-1:0] r_Base;   // line base, low three bits always zero
    logic [2:0]               r_Count;  // halfword index within the line
    logic [MEM_WIDTH-1:0]     r_Hi;     // even halfword waiting for its partner

    // Registered beat outputs
    logic                     r_Valid_p0;
    logic                     r_Last_p0;
    logic [DATA_WIDTH-1:0]    r_Data_p0;

    // Decoded events
    logic w_Reading;
    logic w_Ack;
    logic w_Start;
    logic w_Beat;
    logic w_Final;

    // The memory request stays asserted in DRAIN. An access that has been
    // presented must always be completed by its ack, even after an abort.
    assign w_Reading = (r_State == S_READ) || (r_State == S_DRAIN);

    // Acks are only meaningful while a read is outstanding. Any stray ack in
    // IDLE or RELEASE is dropped here, so the line context cannot be disturbed.
    assign w_Ack     = w_Reading && i_Mem_Ack;

    assign w_Start   = (r_State == S_IDLE) && i_Req_Valid;
    assign w_Final   = (r_Count == 3'd7);

    // A beat completes on the ack of an odd halfword. It is only emitted while
    // the request is still held. A withdrawal in the same cycle suppresses it.
    assign w_Beat    = (r_State == S_READ) && i_Req_Valid && i_Mem_Ack && r_Count[0];

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_State <= S_IDLE;
        end else begin
            r_State <= w_Next_State;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        w_Next_State = r_State;
        case (r_State)
            S_IDLE: begin
                if (i_Req_Valid) begin
                    w_Next_State = S_READ;
                end
            end
            S_READ: begin
                if (!i_Req_Valid) begin
                    // The abort may land on the very cycle the pending access
                    // is acked. In that case nothing is left to drain.
                    if (i_Mem_Ack) begin
                        w_Next_State = S_IDLE;
                    end else begin
                        w_Next_State = S_DRAIN;
                    end
                end else if (i_Mem_Ack && w_Final) begin
                    w_Next_State = S_RELEASE;
                end
            end
            S_DRAIN: begin
                if (i_Mem_Ack) begin
                    w_Next_State = S_IDLE;
                end
            end
            S_RELEASE: begin
                if (!i_Req_Valid) begin
                    w_Next_State = S_IDLE;
                end
            end
            default: begin
                w_Next_State = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Line context: base, halfword index, held upper halfword
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Base  <= '0;
            r_Count <= 3'd0;
            r_Hi    <= '0;
        end else begin
            if (w_Start) begin
                r_Base  <= i_Req_Address & LINE_MASK;
                r_Count <= 3'd0;
            end else if (w_Ack) begin
                // Natural 3-bit wrap. The index never carries into the base.
                r_Count <= 3'(r_Count + 3'd1);
            end

            if (w_Ack && !r_Count[0]) begin
                r_Hi <= i_Mem_Data;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Beat output stage (p0): word assembled on the odd ack, presented next cycle
    // -------------------------------------------------------------------------
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_Valid_p0 <= 1'b0;
            r_Last_p0  <= 1'b0;
            r_Data_p0  <= '0;
        end else begin
            r_Valid_p0 <= w_Beat;
            r_Last_p0  <= w_Beat && w_Final;
            if (w_Beat) begin
                r_Data_p0 <= {r_Hi, i_Mem_Data};
            end
        end
    end

    assign o_Valid       = r_Valid_p0;
    assign o_Last        = r_Last_p0;
    assign o_Data        = r_Data_p0;

    // The base has zero low bits, so OR-ing in the index selects the halfword.
    // Address and read are both derived from registers only. This keeps them
    // stable from assertion through the ack cycle.
    assign o_Mem_Read    = w_Reading;
    assign o_Mem_Address = r_Base | ADDRESS_WIDTH'(r_Count);

endmodule

// File: tb/tb_imem_line_fetch.sv
module tb_imem_line_fetch;

    localparam int AW = 22;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          req;
    logic [AW-1:0] req_addr;
    logic          resp_ack;
    logic          spur_ack;
    logic          mem_ack;
    logic [15:0]   mem_data;
    logic          o_valid;
    logic          o_last;
    logic [31:0]   o_data;
    logic          o_read;
    logic [AW-1:0] o_addr;

    assign mem_ack = resp_ack | spur_ack;

    imem_line_fetch #(
        .DATA_WIDTH   (32),
        .MEM_WIDTH    (16),
        .ADDRESS_WIDTH(AW)
    ) dut (
        .i_Clk        (clk),
        .i_Reset_n    (rst_n),
        .i_Req_Valid  (req),
        .i_Req_Address(req_addr),
        .o_Valid      (o_valid),
        .o_Last       (o_last),
        .o_Data       (o_data),
        .o_Mem_Read   (o_read),
        .o_Mem_Address(o_addr),
        .i_Mem_Ack    (mem_ack),
        .i_Mem_Data   (mem_data)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          delay = 0;
    logic [15:0] xor_val = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: halfword = low 16 address bits, optionally scrambled
    function automatic logic [15:0] hw(input logic [AW-1:0] a);
        return a[15:0] ^ xor_val;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 waiting for request, 1 fetching line, 2 finishing aborted access,
    //       3 line done, waiting for request to drop
    int            m_mode = 0;
    logic [AW-1:0] m_base = '0;
    int            m_idx = 0;
    logic          exp_valid = 1'b0;
    logic          exp_last = 1'b0;
    logic [31:0]   exp_data = 32'h0;
    logic          exp_read;
    logic [AW-1:0] exp_addr;

    assign exp_read = (m_mode == 1) || (m_mode == 2);
    assign exp_addr = m_base + AW'(m_idx);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode    <= 0;
            m_base    <= '0;
            m_idx     <= 0;
            exp_valid <= 1'b0;
            exp_last  <= 1'b0;
            exp_data  <= 32'h0;
        end else begin
            exp_valid <= 1'b0;
            exp_last  <= 1'b0;
            case (m_mode)
                0: if (req) begin
                    m_base <= req_addr & ~AW'(7);
                    m_idx  <= 0;
                    m_mode <= 1;
                end
                1: if (!req) begin
                    m_mode <= mem_ack ? 0 : 2;
                end else if (mem_ack) begin
                    if (m_idx % 2 == 1) begin
                        exp_valid <= 1'b1;
                        exp_last  <= (m_idx == 7);
                        exp_data  <= {hw(m_base + AW'(m_idx - 1)), hw(m_base + AW'(m_idx))};
                    end
                    m_idx <= m_idx + 1;
                    if (m_idx == 7) m_mode <= 3;
                end
                2: if (mem_ack) m_mode <= 0;
                default: if (!req) m_mode <= 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(o_valid), 32'(exp_valid));
            check("last", 32'(o_last), 32'(exp_last));
            check("data", o_data, exp_data);
            check("mem_read", 32'(o_read), 32'(exp_read));
            if (exp_read) check("mem_addr", 32'(o_addr), 32'(exp_addr));
        end
    end

    // ---------------- collectors ----------------
    int            nb = 0;
    int            na = 0;
    logic [31:0]   beats[64];
    int            btime[64];
    logic          blast[64];
    logic [AW-1:0] addrs[128];

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_valid && nb < 64) begin
                beats[nb] <= o_data;
                btime[nb] <= cyc;
                blast[nb] <= o_last;
                nb        <= nb + 1;
            end
            if (o_read && mem_ack && na < 128) begin
                addrs[na] <= o_addr;
                na        <= na + 1;
            end
        end
    end

    // ---------------- memory responder ----------------
    initial begin
        int   wcnt;
        logic prev;
        wcnt     = 0;
        prev     = 1'b0;
        resp_ack = 1'b0;
        mem_data = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_ack && prev) wcnt = 0;
            resp_ack = 1'b0;
            if (o_read) begin
                if (wcnt >= delay) resp_ack = 1'b1;
                else wcnt++;
            end else begin
                wcnt = 0;
            end
            prev     = o_read;
            mem_data = hw(o_addr);
        end
    end

    // ---------------- stimulus ----------------
    int t_drive = 0;
    int nb0 = 0;
    int na0 = 0;

    task automatic drive_req(input logic [AW-1:0] a);
        @(posedge clk);
        #1;
        req      = 1'b1;
        req_addr = a;
        t_drive  = cyc;
    endtask

    task automatic release_req();
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic wait_beats(input int target, input int budget, input string nm);
        int k;
        k = 0;
        while (nb < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        check(nm, 32'(nb >= target), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] e1[4];
        logic        found;
        int          na_h;
        e1 = '{32'h01200121, 32'h01220123, 32'h01240125, 32'h01260127};

        rst_n    = 1'b0;
        req      = 1'b0;
        req_addr = '0;
        spur_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_last", 32'(o_last), 32'd0);
        check("rst_data", o_data, 32'd0);
        check("rst_read", 32'(o_read), 32'd0);
        check("rst_addr", 32'(o_addr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // zero-wait refill
        delay = 0; xor_val = 16'h0000;
        nb0 = nb; na0 = na;
        drive_req(22'h000123);
        wait_beats(nb0 + 4, 60, "t1_beats_seen");
        for (int i = 0; i < 4; i++) check("t1_beat", beats[nb0 + i], e1[i]);
        for (int i = 0; i < 8; i++) check("t1_addr", 32'(addrs[na0 + i]), 32'h120 + 32'(i));
        check("t1_first_latency", 32'(btime[nb0] - t_drive), 32'd3);
        check("t1_last_time", 32'(btime[nb0 + 3] - t_drive), 32'd9);
        check("t1_last_flag4", 32'(blast[nb0 + 3]), 32'd1);
        check("t1_last_flag1", 32'(blast[nb0]), 32'd0);
        release_req();

        // wait states
        delay = 2;
        nb0 = nb;
        drive_req(22'h000123);
        wait_beats(nb0 + 4, 120, "t2_beats_seen");
        for (int i = 0; i < 4; i++) check("t2_beat", beats[nb0 + i], e1[i]);
        for (int i = 1; i < 4; i++) check("t2_spacing", 32'(btime[nb0 + i] - btime[nb0 + i - 1]), 32'd6);
        release_req();

        // request held after last
        delay = 0; xor_val = 16'h5A5A;
        nb0 = nb;
        drive_req(22'h000040);
        wait_beats(nb0 + 4, 60, "t3a_beats_seen");
        na_h = na;
        repeat (3) @(posedge clk);
        #1;
        check("t3_no_reads_held", 32'(na), 32'(na_h));
        req = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b1; req_addr = 22'h000200;
        nb0 = nb; na0 = na;
        wait_beats(nb0 + 4, 60, "t3b_beats_seen");
        check("t3_first_addr", 32'(addrs[na0]), 32'h200);
        check("t3_last_addr", 32'(addrs[na0 + 7]), 32'h207);
        check("t3_beat1", beats[nb0], 32'h585A585B);
        check("t3_beat4", beats[nb0 + 3], 32'h585C585D);
        release_req();

        // abort mid-line
        delay = 3; xor_val = 16'h0000;
        nb0 = nb; na0 = na;
        drive_req(22'h000300);
        wait_beats(nb0 + 2, 120, "t4_two_beats");
        found = 1'b0;
        for (int k = 0; k < 40 && !found; k++) begin
            @(posedge clk);
            #2;
            if (o_read && o_addr[2:0] == 3'd5 && !mem_ack) found = 1'b1;
        end
        check("t4_hw5_pending", 32'(found), 32'd1);
        req = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("t4_no_more_beats", 32'(nb - nb0), 32'd2);
        check("t4_read_low", 32'(o_read), 32'd0);
        check("t4_acks", 32'(na - na0), 32'd6);

        // reset mid-burst
        delay = 0; xor_val = 16'h1111;
        nb0 = nb;
        drive_req(22'h000400);
        wait_beats(nb0 + 1, 40, "t5_first_beat");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid", 32'(o_valid), 32'd0);
        check("t5_rst_last", 32'(o_last), 32'd0);
        check("t5_rst_data", o_data, 32'd0);
        check("t5_rst_read", 32'(o_read), 32'd0);
        check("t5_rst_addr", 32'(o_addr), 32'd0);
        req = 1'b0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        nb0 = nb;
        drive_req(22'h000400);
        wait_beats(nb0 + 4, 60, "t5_beats_seen");
        check("t5_beat1", beats[nb0], 32'h15111510);
        check("t5_beat4", beats[nb0 + 3], 32'h15171516);
        check("t5_last_flag", 32'(blast[nb0 + 3]), 32'd1);
        release_req();

        // spurious acks in IDLE and RELEASE
        delay = 0; xor_val = 16'h0000;
        @(posedge clk); #1; spur_ack = 1'b1;
        @(posedge clk); #1; spur_ack = 1'b0;
        nb0 = nb;
        drive_req(22'h000500);
        wait_beats(nb0 + 4, 60, "t6a_beats_seen");
        @(posedge clk); #1; spur_ack = 1'b1;
        @(posedge clk); #1; spur_ack = 1'b0;
        release_req();
        check("t6_no_extra_beats", 32'(nb - nb0), 32'd4);
        nb0 = nb; na0 = na;
        drive_req(22'h00050B);
        wait_beats(nb0 + 4, 60, "t6b_beats_seen");
        check("t6_first_addr", 32'(addrs[na0]), 32'h508);
        check("t6_beat1", beats[nb0], 32'h05080509);
        check("t6_beat4", beats[nb0 + 3], 32'h050E050F);
        release_req();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
